userport_joy_scan: RTL and testbench



---
 rtl/userport_joy_scan.sv | 175 +++++++++++++++++
 tb/tb_userport_joy_scan.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/userport_joy_scan.sv
// DB15 user-port joystick scanner: drives the adapter's load/clock pins, shifts in 32 bits
// per scan and publishes two double-buffered active-high joystick words with a stuck-low fault flag.
module userport_joy_scan #(
    parameter int CLK_DIV  = 12,
    parameter int SCAN_GAP = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        joy_data,
    output logic        joy_clk,
    output logic        joy_load,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        scan_done,
    output logic        fault
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(SCAN_GAP + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOW,
        ST_HIGH,
        ST_DONE,
        ST_GAP
    } state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [4:0]         bit_reg, bit_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic [31:0]        raw_reg;
    logic [31:0]        bit_we;
    logic               data_meta_reg, data_sync_reg;
    logic               joy_clk_reg, joy_load_reg;
    logic [15:0]        joystick1_reg, joystick2_reg;
    logic               scan_done_reg, fault_reg;
    logic               sample_en;
    logic               tick;

    assign tick = (div_reg == DIV_LAST);

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        gap_next   = gap_reg;
        sample_en  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_LOAD;
                div_next   = '0;
            end
            ST_LOAD: begin
                if (tick) begin
                    state_next = ST_LOW;
                    div_next   = '0;
                    bit_next   = '0;
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
            ST_LOW: begin
                if (tick) begin
                    sample_en  = 1'b1;
                    state_next = ST_HIGH;
                    div_next   = '0;
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    div_next = '0;
                    if (bit_reg == 5'd31) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_LOW;
                        bit_next   = bit_reg + 5'd1;
                    end
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_GAP;
                gap_next   = '0;
            end
            ST_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = ST_LOAD;
                    div_next   = '0;
                end else begin
                    gap_next = gap_reg + GAP_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Dropping enable aborts whatever is in flight and parks the sequencer.
        if (!enable) begin
            state_next = ST_IDLE;
            div_next   = '0;
            bit_next   = '0;
            gap_next   = '0;
            sample_en  = 1'b0;
        end
    end

    // First shifted bit lands in raw[31], so bit k writes raw[31-k].
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_bit_we
            assign bit_we[gi] = sample_en && (bit_reg == 5'(31 - gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            div_reg       <= '0;
            bit_reg       <= '0;
            gap_reg       <= '0;
            raw_reg       <= '0;
            data_meta_reg <= 1'b1;
            data_sync_reg <= 1'b1;
            joy_clk_reg   <= 1'b0;
            joy_load_reg  <= 1'b1;
            joystick1_reg <= '0;
            joystick2_reg <= '0;
            scan_done_reg <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            bit_reg       <= bit_next;
            gap_reg       <= gap_next;
            raw_reg       <= (raw_reg & ~bit_we) | ({32{data_sync_reg}} & bit_we);
            data_meta_reg <= joy_data;
            data_sync_reg <= data_meta_reg;
            joy_clk_reg   <= (state_next == ST_HIGH);
            joy_load_reg  <= (state_next != ST_LOAD);
            if (!enable) begin
                joystick1_reg <= '0;
                joystick2_reg <= '0;
                fault_reg     <= 1'b0;
                scan_done_reg <= 1'b0;
            end else if (state_reg == ST_DONE) begin
                scan_done_reg <= 1'b1;
                if (raw_reg == 32'h0000_0000) begin
                    fault_reg     <= 1'b1;
                    joystick1_reg <= '0;
                    joystick2_reg <= '0;
                end else begin
                    fault_reg     <= 1'b0;
                    joystick1_reg <= ~raw_reg[31:16];
                    joystick2_reg <= ~raw_reg[15:0];
                end
            end else begin
                scan_done_reg <= 1'b0;
            end
        end
    end

    assign joy_clk   = joy_clk_reg;
    assign joy_load  = joy_load_reg;
    assign joystick1 = joystick1_reg;
    assign joystick2 = joystick2_reg;
    assign scan_done = scan_done_reg;
    assign fault     = fault_reg;

endmodule

// File: tb/tb_userport_joy_scan.sv
// Bench for userport_joy_scan: a 74HC165-style adapter model plus a timeline model of the
// scan (offset within the scan period) checked against the DUT every cycle.
module tb_userport_joy_scan;

    localparam int H      = 12;
    localparam int GAP    = 256;
    localparam int T_DONE = 65 * H + 1;
    localparam int PERIOD = 65 * H + 1 + GAP;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        joy_data;
    logic        joy_clk, joy_load, scan_done, fault;
    logic [15:0] joystick1, joystick2;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    bit chk_en    = 1'b0;
    int scan_no   = 0;

    // Adapter model
    logic [31:0] pattern   = 32'h7FFE_BFFF;
    bit          stuck_en  = 1'b0;
    bit          stuck_val = 1'b1;
    logic [31:0] sr        = '1;
    logic        jc_prev   = 1'b0;
    int          rise_cnt  = 0;

    // Timeline model
    bit          m_active = 1'b0;
    int          m_off    = 0;
    logic [31:0] m_raw    = '0;
    logic [15:0] m_j1     = '0;
    logic [15:0] m_j2     = '0;
    logic        m_fault  = 1'b0;

    userport_joy_scan dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .joy_data  (joy_data),
        .joy_clk   (joy_clk),
        .joy_load  (joy_load),
        .joystick1 (joystick1),
        .joystick2 (joystick2),
        .scan_done (scan_done),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign joy_data = stuck_en ? stuck_val : sr[31];

    always @(posedge clk) begin
        if (!joy_load) begin
            sr       <= pattern;
            rise_cnt <= 0;
        end else if (joy_clk && !jc_prev) begin
            sr       <= {sr[30:0], 1'b1};
            rise_cnt <= rise_cnt + 1;
        end
        jc_prev <= joy_clk;
    end

    always @(posedge clk) begin
        bit          act_n;
        int          off_n;
        logic [31:0] raw_n;
        logic [15:0] j1_n, j2_n;
        logic        f_n;
        act_n = m_active;
        off_n = m_off;
        raw_n = m_raw;
        j1_n  = m_j1;
        j2_n  = m_j2;
        f_n   = m_fault;
        if (!reset_n || !enable) begin
            act_n = 1'b0;
            off_n = 0;
            j1_n  = '0;
            j2_n  = '0;
            f_n   = 1'b0;
        end else begin
            if (!act_n) begin
                act_n = 1'b1;
                off_n = 0;
            end else begin
                off_n = (off_n + 1) % PERIOD;
            end
            if (off_n == 0)
                raw_n = stuck_en ? {32{stuck_val}} : pattern;
            if (off_n == T_DONE) begin
                f_n  = (raw_n == 32'h0);
                j1_n = f_n ? 16'h0 : ~raw_n[31:16];
                j2_n = f_n ? 16'h0 : ~raw_n[15:0];
            end
        end
        m_active <= act_n;
        m_off    <= off_n;
        m_raw    <= raw_n;
        m_j1     <= j1_n;
        m_j2     <= j2_n;
        m_fault  <= f_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model joy_load", 32'(joy_load), 32'(!(m_active && m_off < H)));
            check("model joy_clk", 32'(joy_clk),
                  32'(m_active && m_off >= H && m_off < 65 * H && (((m_off - H) / H) % 2 == 1)));
            check("model scan_done", 32'(scan_done), 32'(m_active && m_off == T_DONE));
            check("model joystick1", 32'(joystick1), 32'(m_j1));
            check("model joystick2", 32'(joystick2), 32'(m_j2));
            check("model fault", 32'(fault), 32'(m_fault));
            if (scan_done) check("joy_clk rises per scan", 32'(rise_cnt), 32'd32);
        end
    end

    task automatic wait_done(input int limit, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (scan_done) begin
                at_cyc = cyc;
                scan_no++;
                $display("scan %0d: cycle %0d j1=%h j2=%h fault=%0b", scan_no, cyc, joystick1, joystick2, fault);
                return;
            end
        end
        total_cnt++;
        $display("FAIL scan_done timeout: got none, expected within %0d cycles (cycle %0d)", limit, cyc);
    endtask

    initial begin
        int t0, td, td2, target, extra;
        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset joy_load", 32'(joy_load), 32'd1);
        check("reset joy_clk", 32'(joy_clk), 32'd0);
        check("reset joystick1", 32'(joystick1), 32'h0);
        check("reset joystick2", 32'(joystick2), 32'h0);
        check("reset fault", 32'(fault), 32'd0);
        check("reset scan_done", 32'(scan_done), 32'd0);

        // Pattern capture
        reset_n = 1'b1;
        @(negedge clk);
        check("load after reset release", 32'(joy_load), 32'd0);
        t0 = cyc;
        wait_done(2000, td);
        check("scan_done latency", 32'(td - t0), 32'(T_DONE));
        check("pattern joystick1", 32'(joystick1), 32'h8001);
        check("pattern joystick2", 32'(joystick2), 32'h4000);
        check("pattern fault", 32'(fault), 32'd0);

        // Open line
        stuck_en  = 1'b1;
        stuck_val = 1'b1;
        wait_done(2000, td);
        wait_done(2000, td2);
        check("scan period", 32'(td2 - td), 32'd1037);
        check("open joystick1", 32'(joystick1), 32'h0);
        check("open fault", 32'(fault), 32'd0);

        // Stuck low, then recovery
        stuck_val = 1'b0;
        wait_done(2000, td);
        check("stuck fault", 32'(fault), 32'd1);
        check("stuck joystick2", 32'(joystick2), 32'h0);
        stuck_en = 1'b0;
        wait_done(2000, td);
        check("recover fault", 32'(fault), 32'd0);
        check("recover joystick1", 32'(joystick1), 32'h8001);

        // Enable drop during LOW(10)
        target = td + GAP + H + 20 * H + 4;
        while (cyc < target) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort joy_clk", 32'(joy_clk), 32'd0);
        check("abort joy_load", 32'(joy_load), 32'd1);
        check("abort joystick1", 32'(joystick1), 32'h0);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (scan_done) extra++;
        end
        check("abort no scan_done", 32'(extra), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("reenable load", 32'(joy_load), 32'd0);
        t0 = cyc;
        wait_done(2000, td);
        check("reenable latency", 32'(td - t0), 32'(T_DONE));
        check("reenable joystick2", 32'(joystick2), 32'h4000);

        // Reset during LOW(20) with words latched
        target = td + GAP + H + 40 * H + 5;
        while (cyc < target) @(negedge clk);
        reset_n = 1'b0;
        pattern = 32'h1234_5678;
        @(negedge clk);
        check("midreset joy_load", 32'(joy_load), 32'd1);
        check("midreset joystick1", 32'(joystick1), 32'h0);
        check("midreset scan_done", 32'(scan_done), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        t0 = cyc;
        wait_done(2000, td);
        check("post-reset latency", 32'(td - t0), 32'(T_DONE));
        check("post-reset joystick1", 32'(joystick1), 32'hEDCB);
        check("post-reset joystick2", 32'(joystick2), 32'hA987);

        // Randomized scans with disturbances
        for (int s = 0; s < 8; s++) begin
            int r;
            pattern   = (s % 4 == 3) ? 32'h0 : $urandom;
            stuck_en  = ($urandom_range(0, 3) == 0);
            stuck_val = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 2);
            if (r != 0) begin
                repeat ($urandom_range(1, 900)) @(negedge clk);
                if (r == 1) enable = 1'b0;
                else reset_n = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                pattern = $urandom;
                enable  = 1'b1;
                reset_n = 1'b1;
            end
            wait_done(2500, td);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
